// File: rtl/if_pkg.sv
// Shared constants for the MIPS instruction fetch stage.
package if_pkg;

  localparam int unsigned IMEM_AW_DEFAULT  = 10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Branch targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer catching the instruction word that returns during a stall.
import if_pkg::*;

module fetch_skid_buf (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= INSTR_NOP;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC, one-cycle-latency imem interface, stall skid and redirect handling.
// Define BRANCH_DELAY_SLOT_EN to keep the word in flight at a redirect as the delay slot.
import if_pkg::*;

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  output logic               ImemRead,
  output logic [IMEM_AW-1:0] ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [31:0]        PCAddResult,
  output logic [INSTR_W-1:0] Instruction,
  output logic               FetchValid
);

  logic [31:0]        pc_q;
  logic               inflight_q;
  logic [31:0]        inflight_pc_q;
  logic [31:0]        fetch_pc;
  logic               kill;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;
  logic               skid_load;
  logic               skid_clear;

`ifdef BRANCH_DELAY_SLOT_EN
  assign kill = 1'b0;
`else
  assign kill = Redirect;
`endif

  always_comb begin
    fetch_pc = Redirect ? word_align(RedirectPC) : pc_q;
    ImemRead = !Reset && !Stall;
    ImemAddr = fetch_pc[IMEM_AW+1:2];
    // No read is issued while stalled, so the skid can never be loaded twice.
    skid_load  = inflight_q && Stall && !skid_valid && !kill;
    skid_clear = kill || (skid_valid && !Stall);
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (Reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (ImemData),
    .load_pc    (inflight_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      Instruction   <= INSTR_NOP;
      PCAddResult   <= '0;
      FetchValid    <= 1'b0;
    end else begin
      inflight_q    <= !Stall;
      inflight_pc_q <= fetch_pc;
      if (Stall) begin
        if (Redirect) begin
          pc_q <= fetch_pc;
        end
      end else begin
        pc_q <= fetch_pc + PC_INC;
        // The skid always holds an older word than the read now returning.
        if (skid_valid && !kill) begin
          Instruction <= skid_instr;
          PCAddResult <= skid_pc + PC_INC;
          FetchValid  <= 1'b1;
        end else if (inflight_q && !kill) begin
          Instruction <= ImemData;
          PCAddResult <= inflight_pc_q + PC_INC;
          FetchValid  <= 1'b1;
        end else begin
          Instruction <= INSTR_NOP;
          PCAddResult <= '0;
          FetchValid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan scenarios then random
// stall/redirect/reset traffic against a queue-of-owed-fetches reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned AW = 10;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk;
  logic          Reset;
  logic          Stall;
  logic          Redirect;
  logic [31:0]   RedirectPC;
  logic          ImemRead;
  logic [AW-1:0] ImemAddr;
  logic [31:0]   ImemData;
  logic [31:0]   PCAddResult;
  logic [31:0]   Instruction;
  logic          FetchValid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetched PCs still owed to the output, oldest first.
  logic [31:0] owed_q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_pcadd = '0;
  logic        exp_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  instruction_fetch_unit #(
    .RESET_PC (RST_PC),
    .IMEM_AW  (AW)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .ImemRead    (ImemRead),
    .ImemAddr    (ImemAddr),
    .ImemData    (ImemData),
    .PCAddResult (PCAddResult),
    .Instruction (Instruction),
    .FetchValid  (FetchValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous memory; garbage when not read so stale captures show up.
  always @(posedge clk) begin
    if (ImemRead) ImemData <= mem_word(ImemAddr);
    else          ImemData <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    logic [31:0] fpc;
    logic [31:0] dpc;
    Reset = rst; Stall = stl; Redirect = rdr; RedirectPC = rpc;
    #1;
    fpc = rdr ? {rpc[31:2], 2'b00} : m_pc;
    check("imem_read", 32'(ImemRead), 32'(!rst && !stl));
    if (!rst && !stl) check("imem_addr", 32'(ImemAddr), 32'(fpc[AW+1:2]));
    if (rst) begin
      owed_q.delete();
      m_pc = RST_PC;
      exp_instr = '0; exp_pcadd = '0; exp_valid = 1'b0;
    end else begin
      if (rdr && !DelaySlot) owed_q.delete();
      if (!stl) begin
        if (owed_q.size() > 0) begin
          dpc = owed_q.pop_front();
          exp_instr = mem_word(dpc[AW+1:2]);
          exp_pcadd = dpc + 32'd4;
          exp_valid = 1'b1;
        end else begin
          exp_instr = '0; exp_pcadd = '0; exp_valid = 1'b0;
        end
        owed_q.push_back(fpc);
        m_pc = fpc + 32'd4;
      end else if (rdr) begin
        m_pc = fpc;
      end
    end
    @(posedge clk);
    #1;
    check("fetch_valid", 32'(FetchValid), 32'(exp_valid));
    check("instruction", Instruction, exp_instr);
    check("pc_add_result", PCAddResult, exp_pcadd);
  endtask

  initial begin
    logic [31:0] rpc;
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    // Reset release and straight-line fetch.
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Three-cycle stall with word 2 in flight.
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Redirect to 0x40 with word 5 in flight.
    step(1'b0, 1'b0, 1'b1, 32'h40);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Redirect together with stall.
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Reset while the skid holds a word.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Redirect into the top of the address space; PC+4 wraps to zero.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, rpc);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
